// File: rtl/s27_key_ctrl.sv
// s27_key_ctrl: serial key entry and unlock controller for the locked s27 core.
// Drives S1/S2/RANDOM; repeated wrong keys trip a lockout that only RST clears.
module s27_key_ctrl #(
    parameter int unsigned      KEY_W      = 16,
    parameter logic [KEY_W-1:0] GOLDEN_KEY = 16'hA5C3,
    parameter int unsigned      MAX_TRIES  = 3,
    parameter logic [15:0]      LFSR_SEED  = 16'hACE1
) (
    input  logic       CK,
    input  logic       RST,
    input  logic       KEY_IN,
    input  logic       KEY_VLD,
    input  logic       RELOCK,
    output logic       S1,
    output logic       S2,
    output logic       RANDOM,
    output logic       UNLOCKED,
    output logic       LOCKOUT,
    output logic [3:0] TRIES
);

    localparam int unsigned     CW    = $clog2(KEY_W + 1);
    localparam logic [15:0]     SEED  = (LFSR_SEED == 16'h0) ? 16'h0001 : LFSR_SEED;
    localparam logic [3:0]      TMAX  = 4'(MAX_TRIES);
    localparam logic [CW-1:0]   CLAST = CW'(KEY_W);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_CHECK,
        ST_UNLOCKED,
        ST_LOCKOUT
    } state_t;

    state_t           r_state;
    logic [KEY_W-1:0] r_sreg;
    logic [CW-1:0]    r_cnt;
    logic [3:0]       r_tries;
    logic [15:0]      r_lfsr;
    logic             r_s1;
    logic             r_s2;
    logic             r_random;
    logic             r_unlocked;
    logic             r_lockout;

    logic             w_fb;
    logic [15:0]      w_lfsr_nxt;
    logic [KEY_W-1:0] w_sreg_sh;
    logic [CW-1:0]    w_cnt_inc;
    logic [3:0]       w_tries_inc;

    // LFSR freezes only while the core is running unlocked
    assign w_fb        = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
    assign w_lfsr_nxt  = (r_state == ST_UNLOCKED) ? r_lfsr
                                                  : {r_lfsr[14:0], w_fb};
    assign w_sreg_sh   = {r_sreg[KEY_W-2:0], KEY_IN};
    assign w_cnt_inc   = r_cnt + CW'(1);
    assign w_tries_inc = (r_tries >= TMAX) ? TMAX : r_tries + 4'd1;

    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            r_state    <= ST_IDLE;
            r_sreg     <= '0;
            r_cnt      <= '0;
            r_tries    <= '0;
            r_lfsr     <= SEED;
            r_s1       <= 1'b0;
            r_s2       <= 1'b1;
            r_random   <= SEED[0];
            r_unlocked <= 1'b0;
            r_lockout  <= 1'b0;
        end else begin
            r_lfsr     <= w_lfsr_nxt;
            // Corrupting configuration unless a branch below selects unlock
            r_s1       <= 1'b0;
            r_s2       <= 1'b1;
            r_random   <= w_lfsr_nxt[0];
            r_unlocked <= 1'b0;
            r_lockout  <= 1'b0;

            unique case (r_state)
                ST_IDLE: begin
                    if (KEY_VLD) begin
                        r_sreg  <= w_sreg_sh;
                        r_cnt   <= CW'(1);
                        r_state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (KEY_VLD) begin
                        r_sreg <= w_sreg_sh;
                        r_cnt  <= w_cnt_inc;
                        if (w_cnt_inc == CLAST) begin
                            r_state <= ST_CHECK;
                        end
                    end
                end
                ST_CHECK: begin
                    r_sreg <= '0;
                    r_cnt  <= '0;
                    if (r_sreg == GOLDEN_KEY) begin
                        r_state    <= ST_UNLOCKED;
                        r_tries    <= '0;
                        r_s1       <= 1'b1;
                        r_s2       <= 1'b0;
                        r_random   <= 1'b0;
                        r_unlocked <= 1'b1;
                    end else begin
                        r_tries <= w_tries_inc;
                        if (w_tries_inc == TMAX) begin
                            r_state   <= ST_LOCKOUT;
                            r_lockout <= 1'b1;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                ST_UNLOCKED: begin
                    if (RELOCK) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_s1       <= 1'b1;
                        r_s2       <= 1'b0;
                        r_random   <= 1'b0;
                        r_unlocked <= 1'b1;
                    end
                end
                ST_LOCKOUT: begin
                    r_tries   <= TMAX;
                    r_lockout <= 1'b1;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign S1       = r_s1;
    assign S2       = r_s2;
    assign RANDOM   = r_random;
    assign UNLOCKED = r_unlocked;
    assign LOCKOUT  = r_lockout;
    assign TRIES    = r_tries;

endmodule
